// File: rtl/input_capture_pkg.sv
// Shared constants for the KEY/SW input capture block: register map, bus width,
// and the debounce counter sizing helper.
package input_capture_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_BTN  = 2'd0;
    localparam logic [1:0] ADDR_SW   = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_capture_avs_if.sv
// Avalon-MM slave bus bundle for the input capture block (fixed read latency 1, no waitrequest).
interface input_capture_avs_if;
    import input_capture_pkg::*;

    logic [1:0]        address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/debounce_bit.sv
// Single-bit 2-flop synchroniser followed by a debouncer; rise/fall pulse for one
// cycle in the cycle where dout first shows its new level.
module debounce_bit
    import input_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            dout    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            if (sync_q2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This cycle is the last of the required run of differing samples.
                dout <= sync_q2;
                cnt  <= '0;
                rise <= sync_q2;
                fall <= ~sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_capture_avs.sv
// KEY/SW capture with debouncing, press-event latching and a maskable level irq.
// Define INPUT_CAPTURE_RELEASE_EDGE_EN to also latch release events in EDGE[2*NUM_BTN-1:NUM_BTN].
module input_capture_avs
    import input_capture_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BTN-1:0]    buttons_in,
    input  logic [NUM_SW-1:0]     switches_in,
    input_capture_avs_if.slave    avs,
    output logic                  irq
);

`ifdef INPUT_CAPTURE_RELEASE_EDGE_EN
    localparam int EW = 2 * NUM_BTN;
`else
    localparam int EW = NUM_BTN;
`endif

    logic [NUM_BTN-1:0] btn_stable, btn_rise, btn_fall;
    logic [NUM_SW-1:0]  sw_stable, sw_rise, sw_fall;
    logic [EW-1:0]      edge_set, edge_clr, mask_q, edge_q;
    logic [DATA_W-1:0]  rd_mux;
    logic               wr_mask;
    logic               unused_bits;

    // Pins are inverted before the synchroniser so a reset synchroniser reads as "released".
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (~buttons_in[i]),
            .dout  (btn_stable[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (switches_in[i]),
            .dout  (sw_stable[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

`ifdef INPUT_CAPTURE_RELEASE_EDGE_EN
    assign edge_set    = {btn_fall, btn_rise};
    assign unused_bits = ^{sw_rise, sw_fall, avs.writedata[DATA_W-1:EW]};
`else
    assign edge_set    = btn_rise;
    assign unused_bits = ^{sw_rise, sw_fall, btn_fall, avs.writedata[DATA_W-1:EW]};
`endif

    assign wr_mask  = avs.write && (avs.address == ADDR_MASK);
    assign edge_clr = (avs.write && (avs.address == ADDR_EDGE)) ? avs.writedata[EW-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_BTN:  rd_mux[NUM_BTN-1:0] = btn_stable;
            ADDR_SW:   rd_mux[NUM_SW-1:0]  = sw_stable;
            ADDR_MASK: rd_mux[EW-1:0]      = mask_q;
            ADDR_EDGE: rd_mux[EW-1:0]      = edge_q;
            default:   rd_mux              = '0;
        endcase
    end

    // Reads sample the registers before this cycle's write lands; new events win over W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q            <= '0;
            edge_q            <= '0;
            irq               <= 1'b0;
            avs.readdata      <= '0;
            avs.readdatavalid <= 1'b0;
        end else begin
            avs.readdatavalid <= avs.read;
            if (avs.read) begin
                avs.readdata <= rd_mux;
            end
            if (wr_mask) begin
                mask_q <= avs.writedata[EW-1:0];
            end
            edge_q <= (edge_q & ~edge_clr) | edge_set;
            irq    <= |(edge_q & mask_q);
        end
    end

endmodule

// File: tb/tb_input_capture_avs.sv
// Scoreboard bench for input_capture_avs: directed scenarios then random pins/bus traffic,
// checked against a window-based reference model of the debounced inputs and registers.
module tb_input_capture_avs;
    import input_capture_pkg::*;

    localparam int NB = 4;
    localparam int NS = 10;
    localparam int NT = NB + NS;
    localparam int D  = 4;

`ifdef INPUT_CAPTURE_RELEASE_EDGE_EN
    localparam int          EW       = 2 * NB;
    localparam logic [31:0] EXP_COLL = 32'h23;
    localparam logic [31:0] EXP_REL  = 32'h88;
`else
    localparam int          EW       = NB;
    localparam logic [31:0] EXP_COLL = 32'h03;
    localparam logic [31:0] EXP_REL  = 32'h08;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] buttons_in = '1;
    logic [NS-1:0] switches_in = '0;
    logic          irq;

    int checks = 0;
    int failures = 0;

    input_capture_avs_if avs();

    input_capture_avs #(
        .NUM_BTN         (NB),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buttons_in  (buttons_in),
        .switches_in (switches_in),
        .avs         (avs),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a bit's debounced level flips when the last D synchronised samples
    // (pin values from two cycles earlier) all disagree with it.
    logic [NT-1:0] hist[$];
    logic [NT-1:0] m_stable;
    logic [EW-1:0] m_mask, m_edge, m_events;
    logic          m_irq;
    logic [31:0]   exp_q[$];

    always @(posedge clk) begin
        logic [NT-1:0] nxt_stable, rose, fell;
        logic [EW-1:0] clr;
        logic [31:0]   rv;
        bit            all_diff;
        if (reset) begin
            hist.push_back('0);
            m_stable = '0;
            m_mask   = '0;
            m_edge   = '0;
            m_events = '0;
            m_irq    = 1'b0;
            exp_q.delete();
        end else begin
            if (avs.read) begin
                rv = '0;
                case (avs.address)
                    ADDR_BTN:  rv[NB-1:0] = m_stable[NB-1:0];
                    ADDR_SW:   rv[NS-1:0] = m_stable[NT-1:NB];
                    ADDR_MASK: rv[EW-1:0] = m_mask;
                    default:   rv[EW-1:0] = m_edge;
                endcase
                exp_q.push_back(rv);
            end
            nxt_stable = m_stable;
            rose = '0;
            fell = '0;
            for (int b = 0; b < NT; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++)
                    if (hist[hist.size() - 2 - k][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) begin
                    nxt_stable[b] = ~m_stable[b];
                    if (m_stable[b]) fell[b] = 1'b1;
                    else             rose[b] = 1'b1;
                end
            end
            clr    = (avs.write && avs.address == ADDR_EDGE) ? avs.writedata[EW-1:0] : '0;
            m_irq  = |(m_edge & m_mask);
            m_edge = (m_edge & ~clr) | m_events;
            if (avs.write && avs.address == ADDR_MASK) m_mask = avs.writedata[EW-1:0];
`ifdef INPUT_CAPTURE_RELEASE_EDGE_EN
            m_events = {fell[NB-1:0], rose[NB-1:0]};
`else
            m_events = rose[NB-1:0];
`endif
            m_stable = nxt_stable;
            hist.push_back({switches_in, ~buttons_in});
        end
        if (hist.size() > 32) void'(hist.pop_front());
    end

    // Monitor: pops an expected response whenever the DUT presents one.
    logic [31:0] last_rd = '0;
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (reset) begin
            last_rd = '0;
        end else begin
            checks++;
            if (avs.readdatavalid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL rdvalid actual=%0b required=%0b t=%0t", avs.readdatavalid,
                         (exp_q.size() != 0), $time);
            end
            checks++;
            if (avs.readdatavalid && exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                if (avs.readdata !== exp_v) begin
                    failures++;
                    $display("FAIL rddata actual=0x%0h required=0x%0h t=%0t", avs.readdata, exp_v, $time);
                end
                last_rd = exp_v;
            end else if (avs.readdata !== last_rd) begin
                failures++;
                $display("FAIL rd_hold actual=0x%0h required=0x%0h t=%0t", avs.readdata, last_rd, $time);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL irq actual=%0b required=%0b t=%0t", irq, m_irq, $time);
            end
        end
    end

    task automatic read_expect(input logic [1:0] a, input logic [31:0] exp_v, input string nm);
        avs.read    = 1'b1;
        avs.address = a;
        @(negedge clk);
        avs.read = 1'b0;
        checks++;
        if (avs.readdata !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, avs.readdata, exp_v);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        avs.write     = 1'b1;
        avs.address   = a;
        avs.writedata = d;
        @(negedge clk);
        avs.write = 1'b0;
    endtask

    task automatic check_irq(input logic exp_v, input string nm);
        checks++;
        if (irq !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", nm, irq, exp_v);
        end
    endtask

    initial begin
        int idx, r;
        avs.read      = 1'b0;
        avs.write     = 1'b0;
        avs.address   = '0;
        avs.writedata = '0;
        repeat (8) @(negedge clk);
        reset = 1'b0;

        read_expect(ADDR_BTN,  32'h0, "rst_btn");
        read_expect(ADDR_SW,   32'h0, "rst_sw");
        read_expect(ADDR_MASK, 32'h0, "rst_mask");
        read_expect(ADDR_EDGE, 32'h0, "rst_edge");
        check_irq(1'b0, "rst_irq");

        // Button 0 pressed: stable after 2+4 cycles, EDGE one cycle later, irq masked.
        buttons_in = 4'b1110;
        repeat (5) @(negedge clk);
        read_expect(ADDR_BTN,  32'h0, "btn0_early");
        read_expect(ADDR_BTN,  32'h1, "btn0_stable");
        read_expect(ADDR_EDGE, 32'h1, "btn0_edge");
        check_irq(1'b0, "btn0_masked_irq");

        // Glitching switch 3 never settles; then held high it settles after the full debounce.
        for (int i = 0; i < 4; i++) begin
            switches_in[3] = ~switches_in[3];
            repeat (3) @(negedge clk);
        end
        read_expect(ADDR_SW, 32'h0, "sw_glitch");
        switches_in[3] = 1'b1;
        repeat (5) @(negedge clk);
        read_expect(ADDR_SW, 32'h0, "sw_settling");
        read_expect(ADDR_SW, 32'h8, "sw_stable");

        // Masked press raises irq; W1C drops it one cycle after the write.
        write_reg(ADDR_MASK, 32'h4);
        buttons_in = 4'b1010;
        repeat (8) @(negedge clk);
        check_irq(1'b1, "btn2_irq");
        write_reg(ADDR_EDGE, 32'h4);
        check_irq(1'b1, "w1c_irq_same");
        @(negedge clk);
        check_irq(1'b0, "w1c_irq_low");

        // W1C colliding with a fresh press: set wins.
        buttons_in = 4'b1000;
        repeat (8) @(negedge clk);
        write_reg(ADDR_MASK, 32'h2);
        buttons_in = 4'b1010;
        repeat (8) @(negedge clk);
        buttons_in = 4'b1000;
        for (int i = 0; i < 40 && !m_events[1]; i++) @(negedge clk);
        checks++;
        if (!m_events[1]) begin
            failures++;
            $display("FAIL collide_wait actual=timeout required=press_event");
        end
        write_reg(ADDR_EDGE, 32'h2);
        @(negedge clk);
        check_irq(1'b1, "collide_irq");
        read_expect(ADDR_EDGE, EXP_COLL, "collide_edge");

        // Press then release button 3 from a cleared EDGE.
        buttons_in = 4'b1111;
        repeat (10) @(negedge clk);
        write_reg(ADDR_EDGE, 32'hFF);
        buttons_in = 4'b0111;
        repeat (8) @(negedge clk);
        buttons_in = 4'b1111;
        repeat (8) @(negedge clk);
        read_expect(ADDR_EDGE, EXP_REL, "release_edge");

        // Reset mid-debounce with the button held: one event after reset.
        buttons_in = 4'b1110;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        read_expect(ADDR_BTN,  32'h1, "held_thru_reset");
        read_expect(ADDR_EDGE, 32'h1, "held_event");

        for (int i = 0; i < 1500; i++) begin
            avs.read  = 1'b0;
            avs.write = 1'b0;
            if (i == 700) begin
                reset = 1'b1;
                repeat (6) @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, NT - 1));
                if (idx < NB) buttons_in[idx] = ~buttons_in[idx];
                else          switches_in[idx - NB] = ~switches_in[idx - NB];
            end
            r = int'($urandom_range(0, 9));
            avs.address   = 2'($urandom_range(0, 3));
            avs.writedata = $urandom;
            if (r < 4 || r == 6) avs.read  = 1'b1;
            if (r >= 4 && r <= 6) avs.write = 1'b1;
            @(negedge clk);
        end
        avs.read  = 1'b0;
        avs.write = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
